ps2_ascii_decoder: RTL and testbench
====================================

Name: ps2_ascii_decoder

Overview:
Parametrised PS/2 set-2 scan-code to ASCII decoder with an output FIFO. It consumes the byte stream from the keyboard receiver, parses make/break/extended prefixes, and tracks shift and caps-lock state. It also optionally suppresses typematic repeats. Decoded characters are queued for a consumer (terminal/text engine) that pops them with a read strobe.

Parameters:
FIFO_DEPTH, 8, character queue depth; power of two, 2..64
REPEAT_SUPPRESS, 0, 1 = drop repeated make codes of a held key until its break arrives

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
scan_valid  in  1  one-cycle strobe: scan_code valid this cycle
scan_code  in  8  raw set-2 byte from keyboard receiver
ascii_read  in  1  pop head of FIFO this cycle (ignored when empty)
ascii_ready  out  1  FIFO non-empty
ascii  out  7  FIFO head character; 7'h00 when empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: a character was dropped because FIFO was full
shift_held  out  1  left or right shift currently held
caps_lock  out  1  caps-lock toggle state

Behaviour:
- Reset (async, resetn=0): parser state IDLE, shift flags 0, caps_lock 0, last-make register 8'h00, FIFO emptied. Outputs ascii_ready=0, ascii=0, fifo_count=0, overflow=0.
- Parser FSM, advances only on scan_valid:
  - IDLE: E0->EXT, F0->BREAK. Bytes AA, FA, EE, FE, 00, FF are ignored and stay in IDLE. Any other byte is a make code and returns to IDLE.
  - BREAK: byte is the break code; -> IDLE.
  - EXT: F0->EXT_BREAK; other byte is an extended make; -> IDLE.
  - EXT_BREAK: extended break; -> IDLE.
- Modifiers:
  - Make 12/59 sets left/right shift; break clears them. shift_held = L|R.
  - Make 58 toggles caps_lock. A repeated 58 without an intervening break does not toggle again, regardless of REPEAT_SUPPRESS.
- Mapping for non-modifier make codes:
  - Letters (1C=a ... 1A=z per set 2): lowercase if shift_held==caps_lock, else uppercase.
  - Digits row and punctuation: shifted glyph when shift_held, e.g. 16 -> '1' / '!'.
  - 29 -> 0x20; 5A -> 0x0A; 66 -> 0x08; 0D -> 0x09; 76 -> 0x1B.
  - Extended: E0 5A -> 0x0A, E0 4A -> '/'. All other extended codes are discarded.
  - Unmapped codes and all non-modifier breaks produce no character.
- Repeat: when REPEAT_SUPPRESS=1, a make equal to the last-make register is dropped. Any break clears the last-make register.
- Latency: a byte sampled on edge E pushes its character on edge E+1. ascii_ready is high in the cycle after E+1.
- FIFO rules:
  - Push when full: character dropped, overflow set (cleared only by reset).
  - Push and pop in the same cycle when full: both are accepted and count is unchanged.
  - Push and pop in the same cycle otherwise: count is unchanged.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- scan_valid while a previous push is pending in the pipeline: both bytes are processed in order; there is no back-pressure on the input.

Optional Feature:
Macro PS2_CTRL_KEYS_EN.
- Defined: track left ctrl (14) and right ctrl (E0 14). While either is held, letter makes emit control codes 0x01-0x1A (a=0x01), overriding shift and caps. Extra output ctrl_held (1 bit, reset 0).
- Undefined: ctrl codes are ignored, letters map normally, and the ctrl_held port is absent.

Test Plan:
- Reset, then 1C, F0 1C -> one entry 0x61; ascii_ready=1, fifo_count=1; the pop returns 0x61 and ascii_ready then drops to 0.
- 12, 1C, F0 1C, F0 12, 1C -> FIFO holds 0x41 then 0x61; shift_held=0 at end.
- 58, F0 58, 1C, 12, 1C -> caps_lock=1; FIFO holds 0x41 then 0x61 (shift inverts caps).
- Depth 8: push 9 letters with no reads -> fifo_count=8, overflow=1, head is the first letter. A simultaneous push+pop at full keeps count 8.
- REPEAT_SUPPRESS=1: 1C,1C,1C, F0 1C, 1C -> exactly two 0x61 entries. With REPEAT_SUPPRESS=0 the same stream gives four.
- E0 5A -> 0x0A. E0 75 -> nothing. AA -> nothing, FSM stays in IDLE. Assert resetn low between F0 and 1C -> FIFO empty, and a following 1C produces 0x61 (not treated as a break).

Source files
------------

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with modifier tracking and an output character FIFO.
// Optional left/right ctrl support is compiled in with `define PS2_CTRL_KEYS_EN.
module ps2_ascii_decoder #(
    parameter int FIFO_DEPTH      = 8,
    parameter int REPEAT_SUPPRESS = 0
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          scan_valid,
    input  logic [7:0]                    scan_code,
    input  logic                          ascii_read,
    output logic                          ascii_ready,
    output logic [6:0]                    ascii,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          shift_held,
`ifdef PS2_CTRL_KEYS_EN
    output logic                          ctrl_held,
`endif
    output logic                          caps_lock
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    state_t        state;
    logic          shift_l, shift_r, caps_down;
    logic [7:0]    last_make;
    logic          push_valid;
    logic [6:0]    push_char;
    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          ctrl_active;

    // {hit, letter index 0..25}
    function automatic logic [5:0] letter_lookup(input logic [7:0] code);
        case (code)
            8'h1C: letter_lookup = {1'b1, 5'd0};   8'h32: letter_lookup = {1'b1, 5'd1};
            8'h21: letter_lookup = {1'b1, 5'd2};   8'h23: letter_lookup = {1'b1, 5'd3};
            8'h24: letter_lookup = {1'b1, 5'd4};   8'h2B: letter_lookup = {1'b1, 5'd5};
            8'h34: letter_lookup = {1'b1, 5'd6};   8'h33: letter_lookup = {1'b1, 5'd7};
            8'h43: letter_lookup = {1'b1, 5'd8};   8'h3B: letter_lookup = {1'b1, 5'd9};
            8'h42: letter_lookup = {1'b1, 5'd10};  8'h4B: letter_lookup = {1'b1, 5'd11};
            8'h3A: letter_lookup = {1'b1, 5'd12};  8'h31: letter_lookup = {1'b1, 5'd13};
            8'h44: letter_lookup = {1'b1, 5'd14};  8'h4D: letter_lookup = {1'b1, 5'd15};
            8'h15: letter_lookup = {1'b1, 5'd16};  8'h2D: letter_lookup = {1'b1, 5'd17};
            8'h1B: letter_lookup = {1'b1, 5'd18};  8'h2C: letter_lookup = {1'b1, 5'd19};
            8'h3C: letter_lookup = {1'b1, 5'd20};  8'h2A: letter_lookup = {1'b1, 5'd21};
            8'h1D: letter_lookup = {1'b1, 5'd22};  8'h22: letter_lookup = {1'b1, 5'd23};
            8'h35: letter_lookup = {1'b1, 5'd24};  8'h1A: letter_lookup = {1'b1, 5'd25};
            default: letter_lookup = 6'd0;
        endcase
    endfunction

    // {hit, unshifted glyph, shifted glyph}
    function automatic logic [14:0] glyph_lookup(input logic [7:0] code);
        case (code)
            8'h16: glyph_lookup = {1'b1, 7'h31, 7'h21};  8'h1E: glyph_lookup = {1'b1, 7'h32, 7'h40};
            8'h26: glyph_lookup = {1'b1, 7'h33, 7'h23};  8'h25: glyph_lookup = {1'b1, 7'h34, 7'h24};
            8'h2E: glyph_lookup = {1'b1, 7'h35, 7'h25};  8'h36: glyph_lookup = {1'b1, 7'h36, 7'h5E};
            8'h3D: glyph_lookup = {1'b1, 7'h37, 7'h26};  8'h3E: glyph_lookup = {1'b1, 7'h38, 7'h2A};
            8'h46: glyph_lookup = {1'b1, 7'h39, 7'h28};  8'h45: glyph_lookup = {1'b1, 7'h30, 7'h29};
            8'h0E: glyph_lookup = {1'b1, 7'h60, 7'h7E};  8'h4E: glyph_lookup = {1'b1, 7'h2D, 7'h5F};
            8'h55: glyph_lookup = {1'b1, 7'h3D, 7'h2B};  8'h54: glyph_lookup = {1'b1, 7'h5B, 7'h7B};
            8'h5B: glyph_lookup = {1'b1, 7'h5D, 7'h7D};  8'h5D: glyph_lookup = {1'b1, 7'h5C, 7'h7C};
            8'h4C: glyph_lookup = {1'b1, 7'h3B, 7'h3A};  8'h52: glyph_lookup = {1'b1, 7'h27, 7'h22};
            8'h41: glyph_lookup = {1'b1, 7'h2C, 7'h3C};  8'h49: glyph_lookup = {1'b1, 7'h2E, 7'h3E};
            8'h4A: glyph_lookup = {1'b1, 7'h2F, 7'h3F};  8'h29: glyph_lookup = {1'b1, 7'h20, 7'h20};
            8'h5A: glyph_lookup = {1'b1, 7'h0A, 7'h0A};  8'h66: glyph_lookup = {1'b1, 7'h08, 7'h08};
            8'h0D: glyph_lookup = {1'b1, 7'h09, 7'h09};  8'h76: glyph_lookup = {1'b1, 7'h1B, 7'h1B};
            default: glyph_lookup = 15'd0;
        endcase
    endfunction

`ifdef PS2_CTRL_KEYS_EN
    logic ctrl_l, ctrl_r;
    assign ctrl_active = ctrl_l | ctrl_r;
    assign ctrl_held   = ctrl_active;
`else
    assign ctrl_active = 1'b0;
`endif

    assign shift_held = shift_l | shift_r;

    logic        is_make, is_break, is_xmake, is_xbreak, char_valid, repeat_hit;
    logic [5:0]  letter;
    logic [14:0] glyph;
    logic [6:0]  char_val;

    always_comb begin
        is_make    = 1'b0;
        is_break   = 1'b0;
        is_xmake   = 1'b0;
        is_xbreak  = 1'b0;
        char_valid = 1'b0;
        char_val   = 7'h00;
        letter     = letter_lookup(scan_code);
        glyph      = glyph_lookup(scan_code);
        if (scan_valid) begin
            case (state)
                IDLE:      is_make = !(scan_code inside {8'hE0, 8'hF0, 8'hAA, 8'hFA,
                                                         8'hEE, 8'hFE, 8'h00, 8'hFF});
                BREAK:     is_break  = 1'b1;
                EXT:       is_xmake  = (scan_code != 8'hF0);
                EXT_BREAK: is_xbreak = 1'b1;
                default:   ;
            endcase
        end
        if (is_make) begin
            if (letter[5]) begin
                char_valid = 1'b1;
                if (ctrl_active)
                    char_val = {2'b00, letter[4:0]} + 7'd1;
                else if (shift_held ^ caps_lock)
                    char_val = 7'h41 + {2'b00, letter[4:0]};
                else
                    char_val = 7'h61 + {2'b00, letter[4:0]};
            end else if (glyph[14]) begin
                char_valid = 1'b1;
                char_val   = shift_held ? glyph[6:0] : glyph[13:7];
            end
        end else if (is_xmake) begin
            if (scan_code == 8'h5A) begin
                char_valid = 1'b1;
                char_val   = 7'h0A;
            end else if (scan_code == 8'h4A) begin
                char_valid = 1'b1;
                char_val   = 7'h2F;
            end
        end
        repeat_hit = (REPEAT_SUPPRESS != 0) && (scan_code == last_make);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            caps_lock  <= 1'b0;
            caps_down  <= 1'b0;
            last_make  <= 8'h00;
            push_valid <= 1'b0;
            push_char  <= 7'h00;
`ifdef PS2_CTRL_KEYS_EN
            ctrl_l     <= 1'b0;
            ctrl_r     <= 1'b0;
`endif
        end else begin
            if (scan_valid) begin
                case (state)
                    IDLE:      if (scan_code == 8'hE0)      state <= EXT;
                               else if (scan_code == 8'hF0) state <= BREAK;
                    EXT:       state <= (scan_code == 8'hF0) ? EXT_BREAK : IDLE;
                    default:   state <= IDLE;
                endcase
            end
            if (is_make) begin
                last_make <= scan_code;
                if (scan_code == 8'h12) shift_l <= 1'b1;
                if (scan_code == 8'h59) shift_r <= 1'b1;
                // Typematic repeats of caps-lock must not re-toggle until released
                if (scan_code == 8'h58) begin
                    caps_down <= 1'b1;
                    if (!caps_down) caps_lock <= !caps_lock;
                end
`ifdef PS2_CTRL_KEYS_EN
                if (scan_code == 8'h14) ctrl_l <= 1'b1;
`endif
            end
            if (is_break) begin
                last_make <= 8'h00;
                if (scan_code == 8'h12) shift_l   <= 1'b0;
                if (scan_code == 8'h59) shift_r   <= 1'b0;
                if (scan_code == 8'h58) caps_down <= 1'b0;
`ifdef PS2_CTRL_KEYS_EN
                if (scan_code == 8'h14) ctrl_l <= 1'b0;
`endif
            end
            if (is_xmake) begin
                last_make <= scan_code;
`ifdef PS2_CTRL_KEYS_EN
                if (scan_code == 8'h14) ctrl_r <= 1'b1;
`endif
            end
            if (is_xbreak) begin
                last_make <= 8'h00;
`ifdef PS2_CTRL_KEYS_EN
                if (scan_code == 8'h14) ctrl_r <= 1'b0;
`endif
            end
            push_valid <= char_valid && !repeat_hit;
            push_char  <= char_val;
        end
    end

    logic do_pop, do_push;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
    assign do_pop  = ascii_read && (count != '0);
    assign do_push = push_valid && ((count != FULL) || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_char;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_valid && !do_push) overflow <= 1'b1;
        end
    end

    assign ascii_ready = (count != '0);
    assign ascii       = ascii_ready ? mem[rd_ptr] : 7'h00;
    assign fifo_count  = count;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Bench for ps2_ascii_decoder: two instances (repeat suppression off/on) checked every cycle
// against a prefix-flag/shift-array model, plus literal expectations from the test plan.
module tb_ps2_ascii_decoder;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       ascii_read = 1'b0;

    logic       rdy [2];
    logic [6:0] asc [2];
    logic [3:0] cnt [2];
    logic       ovf [2];
    logic       shf [2];
    logic       cap [2];
`ifdef PS2_CTRL_KEYS_EN
    logic       ctl [2];
`endif

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    ps2_ascii_decoder #(.FIFO_DEPTH(8), .REPEAT_SUPPRESS(0)) dut0 (
        .clock(clock), .resetn(resetn), .scan_valid(scan_valid), .scan_code(scan_code),
        .ascii_read(ascii_read), .ascii_ready(rdy[0]), .ascii(asc[0]), .fifo_count(cnt[0]),
        .overflow(ovf[0]), .shift_held(shf[0]),
`ifdef PS2_CTRL_KEYS_EN
        .ctrl_held(ctl[0]),
`endif
        .caps_lock(cap[0]));

    ps2_ascii_decoder #(.FIFO_DEPTH(8), .REPEAT_SUPPRESS(1)) dut1 (
        .clock(clock), .resetn(resetn), .scan_valid(scan_valid), .scan_code(scan_code),
        .ascii_read(ascii_read), .ascii_ready(rdy[1]), .ascii(asc[1]), .fifo_count(cnt[1]),
        .overflow(ovf[1]), .shift_held(shf[1]),
`ifdef PS2_CTRL_KEYS_EN
        .ctrl_held(ctl[1]),
`endif
        .caps_lock(cap[1]));

    // ---------------- behavioural model ----------------
    byte unsigned letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                        8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                        8'h35, 8'h1A};
    byte unsigned glyph_codes [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                       8'h46, 8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D,
                                       8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
    byte unsigned glyph_plain [21] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                                       8'h39, 8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C,
                                       8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
    byte unsigned glyph_shift [21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A,
                                       8'h28, 8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C,
                                       8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};

    bit         m_e0 [2], m_f0 [2], m_shl [2], m_shr [2], m_caps [2], m_capsdown [2];
    bit         m_ctl [2], m_ctr [2], m_ovf [2], pend_v [2];
    logic [7:0] m_last [2];
    logic [6:0] pend_c [2];
    logic [6:0] q [2][8];
    int         qn [2];

    // {valid, char}
    function automatic logic [7:0] model_char(input logic [7:0] code, input bit ext,
                                              input bit shift, input bit caps, input bit ctrl);
        if (ext) begin
            if (code == 8'h5A) return 8'h8A;
            if (code == 8'h4A) return 8'hAF;
            return 8'h00;
        end
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) begin
                if (ctrl) return 8'h80 | 8'(i + 1);
                return 8'h80 | 8'((shift != caps) ? 65 + i : 97 + i);
            end
        for (int i = 0; i < 21; i++)
            if (glyph_codes[i] == code)
                return 8'h80 | (shift ? glyph_shift[i] : glyph_plain[i]);
        case (code)
            8'h29:   return 8'hA0;
            8'h5A:   return 8'h8A;
            8'h66:   return 8'h88;
            8'h0D:   return 8'h89;
            8'h76:   return 8'h9B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_byte(input int m, input logic [7:0] b);
        bit ext;
        logic [7:0] r;
        if (m_f0[m]) begin
            ext = m_e0[m];
            m_f0[m] = 0;
            m_e0[m] = 0;
            m_last[m] = 8'h00;
            if (!ext) begin
                if (b == 8'h12) m_shl[m] = 0;
                if (b == 8'h59) m_shr[m] = 0;
                if (b == 8'h58) m_capsdown[m] = 0;
                if (b == 8'h14) m_ctl[m] = 0;
            end else if (b == 8'h14) m_ctr[m] = 0;
        end else if (b == 8'hF0) begin
            m_f0[m] = 1;
        end else if (b == 8'hE0 && !m_e0[m]) begin
            m_e0[m] = 1;
        end else if (!m_e0[m] && (b == 8'hAA || b == 8'hFA || b == 8'hEE ||
                                  b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
        end else begin
            ext = m_e0[m];
            m_e0[m] = 0;
`ifdef PS2_CTRL_KEYS_EN
            r = model_char(b, ext, m_shl[m] | m_shr[m], m_caps[m], m_ctl[m] | m_ctr[m]);
`else
            r = model_char(b, ext, m_shl[m] | m_shr[m], m_caps[m], 1'b0);
`endif
            if (r[7] && !(m == 1 && b == m_last[m])) begin
                pend_v[m] = 1;
                pend_c[m] = r[6:0];
            end
            if (!ext) begin
                if (b == 8'h12) m_shl[m] = 1;
                if (b == 8'h59) m_shr[m] = 1;
                if (b == 8'h14) m_ctl[m] = 1;
                if (b == 8'h58) begin
                    if (!m_capsdown[m]) m_caps[m] = !m_caps[m];
                    m_capsdown[m] = 1;
                end
            end else if (b == 8'h14) m_ctr[m] = 1;
            m_last[m] = b;
        end
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int m = 0; m < 2; m++) begin
                m_e0[m] = 0; m_f0[m] = 0; m_shl[m] = 0; m_shr[m] = 0; m_caps[m] = 0;
                m_capsdown[m] = 0; m_ctl[m] = 0; m_ctr[m] = 0; m_ovf[m] = 0;
                pend_v[m] = 0; pend_c[m] = 7'h00; m_last[m] = 8'h00; qn[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (ascii_read && qn[m] > 0) begin
                    for (int k = 0; k < 7; k++) q[m][k] = q[m][k+1];
                    qn[m]--;
                end
                if (pend_v[m]) begin
                    if (qn[m] < 8) begin
                        q[m][qn[m]] = pend_c[m];
                        qn[m]++;
                    end else m_ovf[m] = 1;
                end
                pend_v[m] = 0;
                if (scan_valid) model_byte(m, scan_code);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    endtask

    always @(posedge clock) begin
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("dut%0d ascii_ready", m), {7'd0, rdy[m]}, {7'd0, qn[m] > 0});
            check($sformatf("dut%0d ascii", m), {1'b0, asc[m]}, (qn[m] > 0) ? {1'b0, q[m][0]} : 8'h00);
            check($sformatf("dut%0d fifo_count", m), {4'd0, cnt[m]}, 8'(qn[m]));
            check($sformatf("dut%0d overflow", m), {7'd0, ovf[m]}, {7'd0, m_ovf[m]});
            check($sformatf("dut%0d shift_held", m), {7'd0, shf[m]}, {7'd0, m_shl[m] | m_shr[m]});
            check($sformatf("dut%0d caps_lock", m), {7'd0, cap[m]}, {7'd0, m_caps[m]});
`ifdef PS2_CTRL_KEYS_EN
            check($sformatf("dut%0d ctrl_held", m), {7'd0, ctl[m]}, {7'd0, m_ctl[m] | m_ctr[m]});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        @(negedge clock);
        scan_valid = 1'b0;
        $display("byte %02h  dut0 count=%0d dut1 count=%0d", b, cnt[0], cnt[1]);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pop();
        ascii_read = 1'b1;
        @(negedge clock);
        ascii_read = 1'b0;
        $display("pop   dut0 head=%02h count=%0d", asc[0], cnt[0]);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        $display("reset");
    endtask

    logic [7:0] nine [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

    initial begin
        settle(2);
        check("reset ascii_ready", {7'd0, rdy[0]}, 8'h00);
        check("reset fifo_count", {4'd0, cnt[0]}, 8'h00);
        resetn = 1'b1;
        settle(1);

        // single letter then pop
        send(8'h1C); send(8'hF0); send(8'h1C); settle(2);
        check("a ready", {7'd0, rdy[0]}, 8'h01);
        check("a count", {4'd0, cnt[0]}, 8'h01);
        check("a head", {1'b0, asc[0]}, 8'h61);
        pop();
        check("a ready after pop", {7'd0, rdy[0]}, 8'h00);

        // shift
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        settle(2);
        check("shift head A", {1'b0, asc[0]}, 8'h41);
        pop();
        check("shift head a", {1'b0, asc[0]}, 8'h61);
        check("shift released", {7'd0, shf[0]}, 8'h00);
        pop();

        // caps lock, shift inverts caps
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); send(8'h12); send(8'h1C); settle(2);
        check("caps on", {7'd0, cap[0]}, 8'h01);
        check("caps head A", {1'b0, asc[0]}, 8'h41);
        pop();
        check("caps+shift head a", {1'b0, asc[0]}, 8'h61);
        pop();
        send(8'hF0); send(8'h12);
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58); settle(1);
        check("caps repeat toggles once", {7'd0, cap[0]}, 8'h00);

        // shifted digit, space, extended slash
        send(8'h12); send(8'h16); send(8'hF0); send(8'h16); send(8'hF0); send(8'h12);
        send(8'h16); send(8'h29); send(8'hE0); send(8'h4A); settle(2);
        check("digit shifted", {1'b0, asc[0]}, 8'h21);
        pop();
        check("digit plain", {1'b0, asc[0]}, 8'h31);
        pop();
        check("space", {1'b0, asc[0]}, 8'h20);
        pop();
        check("ext slash", {1'b0, asc[0]}, 8'h2F);
        pop();

        // overflow, back-to-back bytes
        for (int i = 0; i < 9; i++) send(nine[i]);
        settle(2);
        check("full count", {4'd0, cnt[0]}, 8'h08);
        check("overflow set", {7'd0, ovf[0]}, 8'h01);
        check("full head", {1'b0, asc[0]}, 8'h61);
        scan_valid = 1'b1; scan_code = 8'h42;
        @(negedge clock);
        scan_valid = 1'b0; ascii_read = 1'b1;
        @(negedge clock);
        ascii_read = 1'b0;
        settle(1);
        check("push+pop full count", {4'd0, cnt[0]}, 8'h08);
        check("push+pop full head", {1'b0, asc[0]}, 8'h62);
        repeat (9) pop();
        check("drained", {4'd0, cnt[0]}, 8'h00);
        check("overflow sticky", {7'd0, ovf[0]}, 8'h01);
        do_reset();
        check("overflow cleared", {7'd0, ovf[0]}, 8'h00);

        // repeat suppression
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C); settle(2);
        check("no suppress count", {4'd0, cnt[0]}, 8'h04);
        check("suppress count", {4'd0, cnt[1]}, 8'h02);
        repeat (4) pop();

        // extended codes and ignored bytes
        send(8'hE0); send(8'h5A); settle(2);
        check("ext enter", {1'b0, asc[0]}, 8'h0A);
        pop();
        send(8'hE0); send(8'h75); send(8'hAA); settle(2);
        check("ext discard", {4'd0, cnt[0]}, 8'h00);
        send(8'h1D); settle(2);
        check("after AA", {1'b0, asc[0]}, 8'h77);
        pop();

        // reset in the middle of a break sequence
        send(8'hF0);
        do_reset();
        check("mid reset empty", {4'd0, cnt[0]}, 8'h00);
        send(8'h1C); settle(2);
        check("mid reset make", {1'b0, asc[0]}, 8'h61);
        check("mid reset count", {4'd0, cnt[0]}, 8'h01);
        pop();
        settle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
